// File: rtl/display_scheduler_if.sv
// Bundles the request/data inputs and display outputs shared by the
// game sources and the display scheduler.
interface display_scheduler_if;
  logic [2:0]  req;
  logic [31:0] data0;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [7:0]  en0;
  logic [7:0]  en1;
  logic [7:0]  en2;
  logic [2:0]  grant;
  logic [1:0]  owner;
  logic [31:0] disp_word;
  logic [7:0]  digit_en;
  logic        switch_pulse;

  // Game side: raises requests and supplies digit words, observes the grant.
  modport master (
    output req, data0, data1, data2, en0, en1, en2,
    input  grant, owner, disp_word, digit_en, switch_pulse
  );

  // Scheduler side: arbitrates and drives the display path.
  modport slave (
    input  req, data0, data1, data2, en0, en1, en2,
    output grant, owner, disp_word, digit_en, switch_pulse
  );
endinterface

// File: rtl/display_scheduler.sv
// Fixed-priority owner arbitration of the 8-digit display among alert (0),
// round timer (1) and score (2), with a minimum on-screen hold per grant.
module display_scheduler #(
  parameter int unsigned MIN_HOLD = 100000000,
  parameter int unsigned HOLD_W   = 27
) (
  input logic          clock,
  input logic          reset,
  display_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOCKED, OPEN} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD - 1);
  localparam logic [1:0]        NO_OWNER  = 2'd3;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [2:0]        grant_q;
  logic [1:0]        owner_q;
  logic [31:0]       word_q;
  logic [7:0]        en_q;
  logic              pulse_q;

  logic              pick_valid;
  logic [1:0]        pick;
  logic [2:0]        pick_grant;
  logic [31:0]       pick_word;
  logic [7:0]        pick_en;
  logic              own_req;
  logic [31:0]       own_word;
  logic [7:0]        own_en;
  logic              regrant;

  // Highest-priority requester and the current owner's live request/data.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    pick       = 2'd0;
    pick_grant = 3'b000;
    pick_valid = |bus.req;
    if (bus.req[0]) begin
      pick       = 2'd0;
      pick_grant = 3'b001;
    end else if (bus.req[1]) begin
      pick       = 2'd1;
      pick_grant = 3'b010;
    end else if (bus.req[2]) begin
      pick       = 2'd2;
      pick_grant = 3'b100;
    end

    case (pick)
      2'd0:    begin pick_word = bus.data0; pick_en = bus.en0; end
      2'd1:    begin pick_word = bus.data1; pick_en = bus.en1; end
      default: begin pick_word = bus.data2; pick_en = bus.en2; end
    endcase

    own_req  = 1'b0;
    own_word = bus.data2;
    own_en   = bus.en2;
    case (owner_q)
      2'd0:    begin own_req = bus.req[0]; own_word = bus.data0; own_en = bus.en0; end
      2'd1:    begin own_req = bus.req[1]; own_word = bus.data1; own_en = bus.en1; end
      2'd2:    begin own_req = bus.req[2]; own_word = bus.data2; own_en = bus.en2; end
      default: own_req = 1'b0;
    endcase

    // A new owner is installed from idle, by alert preemption while locked,
    // or once the hold has expired and someone other than the owner wins.
    regrant = 1'b0;
    case (state)
      IDLE:    regrant = pick_valid;
      LOCKED:  regrant = bus.req[0] && (owner_q != 2'd0);
      OPEN:    regrant = pick_valid && (pick != owner_q);
      default: regrant = 1'b0;
    endcase
  end

  // Ownership FSM with registered display outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      grant_q  <= 3'b000;
      owner_q  <= NO_OWNER;
      word_q   <= 32'h0;
      en_q     <= 8'h00;
      pulse_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      pulse_q <= 1'b0;
      if (regrant) begin
        state    <= LOCKED;
        hold_cnt <= HOLD_LOAD;
        grant_q  <= pick_grant;
        owner_q  <= pick;
        word_q   <= pick_word;
        en_q     <= pick_en;
        pulse_q  <= 1'b1;
      end else begin
        case (state)
          LOCKED: begin
            if (hold_cnt == '0) state <= OPEN;
            else                hold_cnt <= hold_cnt - HOLD_W'(1);
            // Owner dropping its request freezes the last shown value.
            if (own_req) begin
              word_q <= own_word;
              en_q   <= own_en;
            end
          end
          OPEN: begin
            if (!pick_valid) begin
              state    <= IDLE;
              hold_cnt <= '0;
              grant_q  <= 3'b000;
              owner_q  <= NO_OWNER;
              word_q   <= 32'h0;
              en_q     <= 8'h00;
              pulse_q  <= 1'b1;
            end else begin
              word_q <= own_word;
              en_q   <= own_en;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.grant        = grant_q;
  assign bus.owner        = owner_q;
  assign bus.disp_word    = word_q;
  assign bus.digit_en     = en_q;
  assign bus.switch_pulse = pulse_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed-vector bench: the driver pushes hand-computed expected outputs
// into a scoreboard; a monitor pops and compares after each output update.
module tb_display_scheduler;

  typedef struct {
    int          vec;
    logic [2:0]  grant;
    logic [1:0]  owner;
    logic [31:0] word;
    logic [7:0]  en;
    logic        pulse;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;
  exp_t sb[$];

  display_scheduler_if bus ();

  display_scheduler #(.MIN_HOLD(4), .HOLD_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [1:0] owner_of(input logic [2:0] g);
    case (g)
      3'b001:  return 2'd0;
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic check(input string name, input int vec, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d: got %h expected %h", name, vec, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] g, input logic [31:0] w, input logic [7:0] e, input logic p);
    exp_t x;
    x.vec   = vec_no;
    x.grant = g;
    x.owner = owner_of(g);
    x.word  = w;
    x.en    = e;
    x.pulse = p;
    sb.push_back(x);
  endtask

  // Apply one vector at the falling edge and record what the next rising edge must produce.
  task automatic step(input logic rst, input logic [2:0] req,
                      input logic [2:0] g, input logic [31:0] w, input logic [7:0] e, input logic p);
    vec_no++;
    // Asynchronous reset must clear outputs without waiting for a clock.
    if (rst && !reset) push_exp(3'b000, 32'h0, 8'h00, 1'b0);
    bus.req = req;
    reset   = rst;
    push_exp(g, w, e, p);
    @(negedge clock);
  endtask

  // Monitor: compare after every clock edge and every reset assertion.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock or posedge reset);
      #2;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("grant",        x.vec, 32'(bus.grant),        32'(x.grant));
        check("owner",        x.vec, 32'(bus.owner),        32'(x.owner));
        check("disp_word",    x.vec, bus.disp_word,         x.word);
        check("digit_en",     x.vec, 32'(bus.digit_en),     32'(x.en));
        check("switch_pulse", x.vec, 32'(bus.switch_pulse), 32'(x.pulse));
      end
    end
  end

  initial begin
    bus.req   = 3'b000;
    bus.data0 = 32'h0;          bus.en0 = 8'h00;
    bus.data1 = 32'hAAAA_0001;  bus.en1 = 8'h3C;
    bus.data2 = 32'h0000_1234;  bus.en2 = 8'h0F;
    @(negedge clock);

    // Reset and idle.
    repeat (2)  step(1, 3'b000, 3'b000, 32'h0, 8'h00, 0);
    repeat (10) step(0, 3'b000, 3'b000, 32'h0, 8'h00, 0);

    // Score owns; live tracking; timer request waits out the hold.
    step(0, 3'b100, 3'b100, 32'h0000_1234, 8'h0F, 1);
    bus.data2 = 32'h0000_1235;
    step(0, 3'b100, 3'b100, 32'h0000_1235, 8'h0F, 0);
    repeat (3) step(0, 3'b110, 3'b100, 32'h0000_1235, 8'h0F, 0);
    step(0, 3'b110, 3'b010, 32'hAAAA_0001, 8'h3C, 1);

    // Alert preempts a locked timer, holds 4 cycles, timer regains after drop.
    bus.data0 = 32'hDEAD_BEEF; bus.en0 = 8'hFF;
    step(0, 3'b011, 3'b001, 32'hDEAD_BEEF, 8'hFF, 1);
    repeat (5) step(0, 3'b011, 3'b001, 32'hDEAD_BEEF, 8'hFF, 0);
    step(0, 3'b010, 3'b010, 32'hAAAA_0001, 8'h3C, 1);

    // Timer drops its request: frozen through the hold, then idle.
    repeat (4) step(0, 3'b000, 3'b010, 32'hAAAA_0001, 8'h3C, 0);
    step(0, 3'b000, 3'b000, 32'h0, 8'h00, 1);
    step(0, 3'b000, 3'b000, 32'h0, 8'h00, 0);

    // One-cycle alert: shown frozen for the whole hold, then idle.
    bus.data0 = 32'h0000_C0DE; bus.en0 = 8'h07;
    step(0, 3'b001, 3'b001, 32'h0000_C0DE, 8'h07, 1);
    bus.data0 = 32'h1111_1111; bus.en0 = 8'hF0;
    repeat (4) step(0, 3'b000, 3'b001, 32'h0000_C0DE, 8'h07, 0);
    step(0, 3'b000, 3'b000, 32'h0, 8'h00, 1);
    step(0, 3'b000, 3'b000, 32'h0, 8'h00, 0);

    // Simultaneous requests, reset mid-hold, request held through release.
    step(0, 3'b111, 3'b001, 32'h1111_1111, 8'hF0, 1);
    step(0, 3'b111, 3'b001, 32'h1111_1111, 8'hF0, 0);
    repeat (2) step(1, 3'b110, 3'b000, 32'h0, 8'h00, 0);
    step(0, 3'b110, 3'b010, 32'hAAAA_0001, 8'h3C, 1);
    step(0, 3'b110, 3'b010, 32'hAAAA_0001, 8'h3C, 0);

    @(posedge clock);
    #3;
    check("scoreboard_drained", vec_no, 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Shares the 8-digit seven-segment display among three game sources: 0 = alert/message, 1 = round timer, 2 = score.
- Grants the display by fixed priority, with a minimum on-screen hold time.
- Drives the 32-bit digit word and per-digit enable mask consumed by the display scan multiplexer. Sits between the game FSM/counters and the display scan/decode path.

Parameters:
- MIN_HOLD, 100000000, minimum cycles a granted source owns the display (≥1; bench uses 4).
- HOLD_W, 27, hold counter width; must satisfy 2^HOLD_W > MIN_HOLD.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- req  in  3  per-source display request; bit 0 has highest priority.
- data0  in  32  source 0 word, 8 hex nibbles, nibble 0 = rightmost digit.
- data1  in  32  source 1 word.
- data2  in  32  source 2 word.
- en0  in  8  source 0 digit enables, 1 = lit.
- en1  in  8  source 1 digit enables.
- en2  in  8  source 2 digit enables.
- grant  out  3  one-hot current owner; 000 when idle.
- owner  out  2  encoded owner (0..2); 3 when idle.
- disp_word  out  32  word to display mux.
- digit_en  out  8  digit enable mask to display mux.
- switch_pulse  out  1  one-cycle pulse on any ownership change, including to or from idle.

Behaviour:
- Reset values (async): state = IDLE, grant = 000, owner = 3, disp_word = 0, digit_en = 8'h00, switch_pulse = 0, hold_cnt = 0.
- All outputs are registered. A request is reflected in outputs 1 cycle after it is sampled.
- States: IDLE, LOCKED, OPEN.
- IDLE:
  - Any req bit set → grant lowest-index set bit, go to LOCKED, load hold_cnt = MIN_HOLD-1, pulse switch_pulse.
  - Otherwise outputs stay at reset values.
- LOCKED:
  - hold_cnt decrements each cycle. At hold_cnt == 0 in LOCKED → OPEN on the next edge.
  - MIN_HOLD = 1 means exactly one LOCKED cycle.
  - Preemption: req[0] while owner ≠ 0 → immediate regrant to 0, reload hold_cnt, stay LOCKED, pulse switch_pulse.
  - Requests from sources 1 and 2 are ignored in LOCKED.
- OPEN:
  - Owner's req still high and no lower-index req → stay OPEN.
  - Any lower-index req → regrant to the highest-priority requester, go to LOCKED, reload, pulse.
  - Owner's req low with another req set → regrant to the highest-priority remaining requester, go to LOCKED, pulse.
  - Owner's req low with no req set → IDLE, clear grant/owner/disp_word/digit_en, pulse.
- Data path, while owned:
  - Owner's req high → disp_word/digit_en track the owner's data/en every cycle (1-cycle latency).
  - Owner's req low during LOCKED → hold last captured values frozen until the hold expires. The owner is kept for the full MIN_HOLD so short alerts stay readable.
- Regrant: on the grant edge, disp_word/digit_en load the new owner's data/en.
- switch_pulse never asserts when the owner is unchanged; it is high for exactly one cycle per change.
- Simultaneous requests: lowest index wins.
- Reset mid-operation: immediate IDLE. A req held through reset deassertion is granted on the first edge after release.
- Owner re-raising req during LOCKED resumes live tracking; there is no extra pulse.

Test Plan:
- Reset, req = 000 → grant = 000, owner = 3, digit_en = 00, disp_word = 0, switch_pulse = 0 for 10 cycles.
- req = 100 (src 2), data2 = 0x00001234, en2 = 0x0F → next cycle grant = 100, owner = 2, disp_word = 0x00001234, digit_en = 0x0F, one-cycle switch_pulse. Change data2 to 0x00001235 → disp_word follows 1 cycle later.
- MIN_HOLD = 4. src 2 owned; raise req[1] at cycle 1 of hold → no change until OPEN. The cycle after OPEN is reached, grant = 010.
- src 1 owned in LOCKED; raise req[0] with data0 = 0xDEADBEEF, en0 = 0xFF → next cycle grant = 001, disp_word = 0xDEADBEEF, hold reloaded; src 1 regains only after 4 cycles plus req[0] drop.
- src 0 pulses req for 1 cycle → grant = 001 held for exactly 4 LOCKED cycles with disp_word frozen; then IDLE with digit_en = 00 and switch_pulse.
- req = 111 simultaneously → grant = 001. Assert reset mid-LOCKED → all outputs at reset values the same cycle. Release with req = 110 → grant = 010 one cycle later.
